// File: rtl/shifter_arbiter.sv
// -----------------------------------------------------------------------------
// shifter_arbiter
//   Two request ports (A and B) share a single barrel shifter and a single
//   result register. One port is granted per cycle, chosen by round-robin or by
//   fixed A priority. Its operands pass straight through the shifter, and the
//   result is captured one edge later.
//
// Ports
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   x_req_valid/x_req_ready : request handshake for port x in {a,b}
//   x_data/x_shamt          : operand and 5-bit shift amount for port x
//   x_dir/x_arith           : 0=left 1=right / sign-fill on right shift
//   x_resp_valid/x_resp_ready: response handshake for port x
//   resp_data               : shared result, owned by whichever resp_valid is high
//   count                   : number of accepted requests (wraps)
// -----------------------------------------------------------------------------
`default_nettype none

module barrel_shifter32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       shamt_i,
  input  logic             dir_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] stage_s [6];
  logic             fill_s;

  // Sign fill applies only to arithmetic right shifts.
  assign fill_s     = dir_i & arith_i & data_i[WIDTH-1];
  assign stage_s[0] = data_i;

  // Five log-steps: stage i shifts by 2**i when shamt bit i is set.
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int SH = 2 ** i;
    logic [WIDTH-1:0] right_s;
    logic [WIDTH-1:0] left_s;
    logic [WIDTH-1:0] fill_mask_s;

    assign fill_mask_s = ~({WIDTH{1'b1}} >> SH) & {WIDTH{fill_s}};
    assign right_s     = (stage_s[i] >> SH) | fill_mask_s;
    assign left_s      = stage_s[i] << SH;
    assign stage_s[i+1] = (shamt_i[i] == 1'b0) ? stage_s[i]
                        : ((dir_i == 1'b1) ? right_s : left_s);
  end

  assign result_o = stage_s[5];

endmodule

module shifter_arbiter #(
  parameter int WIDTH  = 32,
  parameter bit PRIO_A = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [4:0]       a_shamt,
  input  logic             a_dir,
  input  logic             a_arith,
  output logic             a_resp_valid,
  input  logic             a_resp_ready,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [4:0]       b_shamt,
  input  logic             b_dir,
  input  logic             b_arith,
  output logic             b_resp_valid,
  input  logic             b_resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [31:0]      count
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL_A = 2'd1,
    ST_FULL_B = 2'd2
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } port_e;

  state_e           state_q,      state_d;
  port_e            last_grant_q, last_grant_d;
  logic [WIDTH-1:0] resp_data_q,  resp_data_d;
  logic [31:0]      count_q,      count_d;

  logic             can_accept_s;
  logic             drain_s;
  logic             grant_a_s;
  logic             grant_b_s;
  logic [WIDTH-1:0] sh_data_s;
  logic [4:0]       sh_shamt_s;
  logic             sh_dir_s;
  logic             sh_arith_s;
  logic [WIDTH-1:0] sh_result_s;

  // Result slot is free when empty or when its owner drains it this cycle.
  always_comb begin
    can_accept_s = 1'b0;
    drain_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        can_accept_s = 1'b1;
        drain_s      = 1'b0;
      end
      ST_FULL_A: begin
        can_accept_s = a_resp_ready;
        drain_s      = a_resp_ready;
      end
      ST_FULL_B: begin
        can_accept_s = b_resp_ready;
        drain_s      = b_resp_ready;
      end
      default: begin
        can_accept_s = 1'b0;
        drain_s      = 1'b0;
      end
    endcase
  end

  // Grant selection; gating with reset_n keeps ready low while reset is held.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (can_accept_s && reset_n) begin
      if (a_req_valid && b_req_valid) begin
        if ((PRIO_A == 1'b1) || (last_grant_q == GNT_B)) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (a_req_valid) begin
        grant_a_s = 1'b1;
      end else if (b_req_valid) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Shifter operands come straight from the granted port (B only when B wins).
  always_comb begin
    sh_data_s  = a_data;
    sh_shamt_s = a_shamt;
    sh_dir_s   = a_dir;
    sh_arith_s = a_arith;
    if (grant_b_s) begin
      sh_data_s  = b_data;
      sh_shamt_s = b_shamt;
      sh_dir_s   = b_dir;
      sh_arith_s = b_arith;
    end else begin
      sh_data_s  = a_data;
      sh_shamt_s = a_shamt;
      sh_dir_s   = a_dir;
      sh_arith_s = a_arith;
    end
  end

  barrel_shifter32 #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .data_i   (sh_data_s),
    .shamt_i  (sh_shamt_s),
    .dir_i    (sh_dir_s),
    .arith_i  (sh_arith_s),
    .result_o (sh_result_s)
  );

  // Next-state: accept refills the slot, a bare drain empties it, else hold.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_data_d  = resp_data_q;
    count_d      = count_q;
    if (grant_a_s) begin
      state_d      = ST_FULL_A;
      last_grant_d = GNT_A;
      resp_data_d  = sh_result_s;
      count_d      = count_q + 32'd1;
    end else if (grant_b_s) begin
      state_d      = ST_FULL_B;
      last_grant_d = GNT_B;
      resp_data_d  = sh_result_s;
      count_d      = count_q + 32'd1;
    end else if (drain_s) begin
      state_d      = ST_EMPTY;
    end else begin
      state_d      = state_q;
    end
  end

  // State, arbitration history, result and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= GNT_B;
      resp_data_q  <= {WIDTH{1'b0}};
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
      count_q      <= count_d;
    end
  end

  assign a_req_ready  = grant_a_s;
  assign b_req_ready  = grant_b_s;
  assign a_resp_valid = (state_q == ST_FULL_A);
  assign b_resp_valid = (state_q == ST_FULL_B);
  assign resp_data    = resp_data_q;
  assign count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shifter_arbiter
//   Drives two instances (round-robin and fixed-A priority) with the same
//   stimulus. Each instance is compared every cycle against a behavioural model
//   that tracks slot owner, held result, last grant and accept count.
// -----------------------------------------------------------------------------
module tb_shifter_arbiter;

  logic        clock;
  logic        reset_n;
  logic        a_req_valid, b_req_valid;
  logic [31:0] a_data, b_data;
  logic [4:0]  a_shamt, b_shamt;
  logic        a_dir, b_dir, a_arith, b_arith;
  logic        a_resp_ready, b_resp_ready;

  logic [1:0]  a_req_ready_o, b_req_ready_o, a_resp_valid_o, b_resp_valid_o;
  logic [31:0] resp_data_o [2];
  logic [31:0] count_o [2];

  int vectors    = 0;
  int miscompares = 0;

  // model: owner 0=empty 1=A 2=B, last 1=A 2=B, g = grant expected this cycle
  int          m_owner [2];
  logic [31:0] m_data  [2];
  int          m_last  [2];
  logic [31:0] m_count [2];
  int          m_g     [2];

  shifter_arbiter #(.WIDTH(32), .PRIO_A(1'b0)) u_rr (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_o[0]),
    .a_data(a_data), .a_shamt(a_shamt), .a_dir(a_dir), .a_arith(a_arith),
    .a_resp_valid(a_resp_valid_o[0]), .a_resp_ready(a_resp_ready),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_o[0]),
    .b_data(b_data), .b_shamt(b_shamt), .b_dir(b_dir), .b_arith(b_arith),
    .b_resp_valid(b_resp_valid_o[0]), .b_resp_ready(b_resp_ready),
    .resp_data(resp_data_o[0]), .count(count_o[0])
  );

  shifter_arbiter #(.WIDTH(32), .PRIO_A(1'b1)) u_pa (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_o[1]),
    .a_data(a_data), .a_shamt(a_shamt), .a_dir(a_dir), .a_arith(a_arith),
    .a_resp_valid(a_resp_valid_o[1]), .a_resp_ready(a_resp_ready),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_o[1]),
    .b_data(b_data), .b_shamt(b_shamt), .b_dir(b_dir), .b_arith(b_arith),
    .b_resp_valid(b_resp_valid_o[1]), .b_resp_ready(b_resp_ready),
    .resp_data(resp_data_o[1]), .count(count_o[1])
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic dr, input logic ar);
    logic signed [31:0] sd;
    sd = d;
    if (!dr) return d << s;
    else if (ar) return sd >>> s;
    else return d >> s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0;
      m_data[i]  = 32'd0;
      m_last[i]  = 2;
      m_count[i] = 32'd0;
      m_g[i]     = 0;
    end
  endtask

  // Compare both instances against the model for the current input set.
  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int g;
      bit free;
      g = 0;
      free = (m_owner[i] == 0) || (m_owner[i] == 1 && a_resp_ready) ||
             (m_owner[i] == 2 && b_resp_ready);
      if (reset_n && free) begin
        if (a_req_valid && b_req_valid) g = (i == 1 || m_last[i] == 2) ? 1 : 2;
        else if (a_req_valid) g = 1;
        else if (b_req_valid) g = 2;
      end
      m_g[i] = g;
      chk($sformatf("d%0d_a_req_ready", i),  {31'd0, a_req_ready_o[i]},  {31'd0, g == 1});
      chk($sformatf("d%0d_b_req_ready", i),  {31'd0, b_req_ready_o[i]},  {31'd0, g == 2});
      chk($sformatf("d%0d_a_resp_valid", i), {31'd0, a_resp_valid_o[i]}, {31'd0, m_owner[i] == 1});
      chk($sformatf("d%0d_b_resp_valid", i), {31'd0, b_resp_valid_o[i]}, {31'd0, m_owner[i] == 2});
      chk($sformatf("d%0d_resp_data", i), resp_data_o[i], m_data[i]);
      chk($sformatf("d%0d_count", i), count_o[i], m_count[i]);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit drain;
        drain = (m_owner[i] == 1 && a_resp_ready) || (m_owner[i] == 2 && b_resp_ready);
        if (m_g[i] == 1) begin
          m_owner[i] = 1;
          m_data[i]  = ref_shift(a_data, a_shamt, a_dir, a_arith);
          m_last[i]  = 1;
          m_count[i] = m_count[i] + 32'd1;
        end else if (m_g[i] == 2) begin
          m_owner[i] = 2;
          m_data[i]  = ref_shift(b_data, b_shamt, b_dir, b_arith);
          m_last[i]  = 2;
          m_count[i] = m_count[i] + 32'd1;
        end else if (drain) begin
          m_owner[i] = 0;
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    compare_all();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic dr, input logic ar);
    a_req_valid = v; a_data = d; a_shamt = s; a_dir = dr; a_arith = ar;
  endtask

  task automatic set_b(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic dr, input logic ar);
    b_req_valid = v; b_data = d; b_shamt = s; b_dir = dr; b_arith = ar;
  endtask

  function automatic logic [4:0] rand_shamt();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 5'd0;
    else if (r == 1) return 5'd31;
    else return 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_inputs();
    set_a($urandom_range(0, 2) != 0, $urandom, rand_shamt(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    set_b($urandom_range(0, 2) != 0, $urandom, rand_shamt(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    a_resp_ready = ($urandom_range(0, 3) != 0);
    b_resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  logic [31:0] lit_data  [3];
  logic [4:0]  lit_shamt [3];
  logic        lit_dir   [3];
  logic [31:0] lit_exp   [3];

  // Directed scenarios followed by a randomized run.
  initial begin
    lit_data[0] = 32'hDEADBEEF; lit_shamt[0] = 5'd0;  lit_dir[0] = 1'b0; lit_exp[0] = 32'hDEADBEEF;
    lit_data[1] = 32'h00000001; lit_shamt[1] = 5'd31; lit_dir[1] = 1'b0; lit_exp[1] = 32'h80000000;
    lit_data[2] = 32'hF0000000; lit_shamt[2] = 5'd4;  lit_dir[2] = 1'b1; lit_exp[2] = 32'h0F000000;

    reset_n = 1'b0;
    model_reset();
    set_a(1'b1, 32'h12345678, 5'd3, 1'b0, 1'b0);
    set_b(1'b1, 32'h87654321, 5'd3, 1'b1, 1'b1);
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;
    @(negedge clock);
    cycle();
    cycle();
    set_a(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    set_b(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cycle();

    // arithmetic right shift, single requester A
    set_a(1'b1, 32'h80000001, 5'd1, 1'b1, 1'b1);
    #1 chk("first_a_ready", {31'd0, a_req_ready_o[0]}, 32'd1);
    cycle();
    set_a(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    chk("sra_data", resp_data_o[0], 32'hC0000000);
    chk("sra_valid", {31'd0, a_resp_valid_o[0]}, 32'd1);
    chk("sra_count", count_o[0], 32'd1);

    // boundary shift amounts
    for (int k = 0; k < 3; k++) begin
      set_a(1'b1, lit_data[k], lit_shamt[k], lit_dir[k], 1'b0);
      cycle();
      chk($sformatf("lit_shift%0d", k), resp_data_o[0], lit_exp[k]);
    end
    set_a(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

    // both requesting: RR alternates starting with B (last grant was A); prio grants A
    for (int k = 0; k < 6; k++) begin
      set_a(1'b1, $urandom, rand_shamt(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_b(1'b1, $urandom, rand_shamt(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      chk("rr_alt_a", {31'd0, a_req_ready_o[0]}, {31'd0, (k % 2) == 1});
      chk("rr_alt_b", {31'd0, b_req_ready_o[0]}, {31'd0, (k % 2) == 0});
      chk("prio_a_wins", {31'd0, a_req_ready_o[1]}, 32'd1);
      cycle();
    end
    chk("rr_count", count_o[0], 32'd10);
    chk("prio_count", count_o[1], 32'd10);

    // A drops: starved B now granted on the priority instance
    set_a(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("prio_b_after_a", {31'd0, b_req_ready_o[1]}, 32'd1);
    cycle();

    // B result held: A blocked until B drains, accepted on the drain cycle
    b_resp_ready = 1'b0;
    cycle();
    set_b(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    set_a(1'b1, 32'h0000F00F, 5'd8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("held_b_blocks_a", {31'd0, a_req_ready_o[0]}, 32'd0);
      chk("held_b_valid", {31'd0, b_resp_valid_o[0]}, 32'd1);
      cycle();
    end
    b_resp_ready = 1'b1;
    #1 chk("drain_refill_ready", {31'd0, a_req_ready_o[0]}, 32'd1);
    cycle();
    chk("drain_refill_a", {31'd0, a_resp_valid_o[0]}, 32'd1);
    chk("drain_refill_b", {31'd0, b_resp_valid_o[0]}, 32'd0);
    chk("drain_refill_data", resp_data_o[0], 32'h00F00F00);

    // reset pulse while FULL_A
    set_a(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    a_resp_ready = 1'b0;
    cycle();
    chk("full_a_before_rst", {31'd0, a_resp_valid_o[0]}, 32'd1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, a_resp_valid_o[0]}, 32'd0);
    chk("rst_data", resp_data_o[0], 32'd0);
    chk("rst_count", count_o[0], 32'd0);
    cycle();
    reset_n = 1'b1;
    a_resp_ready = 1'b1;
    set_a(1'b1, 32'h00000003, 5'd1, 1'b0, 1'b0);
    set_b(1'b1, 32'h00000005, 5'd1, 1'b0, 1'b0);
    #1 chk("post_rst_conflict_a", {31'd0, a_req_ready_o[0]}, 32'd1);
    cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
